// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, collects out-of-order
// writebacks, and retires up to MACHINE_WIDTH completed entries per cycle in order.
module rob #(
    parameter int MACHINE_WIDTH = 2,
    parameter int ROB_DEPTH     = 16,
    parameter int DATA_W        = 32,
    localparam int ID_W         = $clog2(ROB_DEPTH),
    localparam int DST_W        = 7
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 flush,
    input  logic [MACHINE_WIDTH-1:0]             alloc_valid,
    input  logic [MACHINE_WIDTH-1:0][DST_W-1:0]  alloc_dst,
    output logic                                 alloc_ready,
    output logic [MACHINE_WIDTH-1:0][ID_W-1:0]   rob_addr_new,
    input  logic [MACHINE_WIDTH-1:0]             wb_valid,
    input  logic [MACHINE_WIDTH-1:0][ID_W-1:0]   wb_id,
    input  logic [MACHINE_WIDTH-1:0][DATA_W-1:0] wb_data,
    output logic [MACHINE_WIDTH-1:0]             retire_valid,
    output logic [MACHINE_WIDTH-1:0][DST_W-1:0]  retire_dst,
    output logic [MACHINE_WIDTH-1:0][ID_W-1:0]   retire_preg,
    output logic [MACHINE_WIDTH-1:0][DATA_W-1:0] retire_data,
    output logic                                 empty
);

    localparam logic [ID_W:0] PTR_ONE = {{ID_W{1'b0}}, 1'b1};

    logic [ID_W:0]          head_q, head_d;
    logic [ID_W:0]          tail_q, tail_d;
    logic [ROB_DEPTH-1:0]   valid_q, valid_d;
    logic [ROB_DEPTH-1:0]   done_q, done_d;
    logic [DST_W-1:0]       dst_q  [ROB_DEPTH];
    logic [DST_W-1:0]       dst_d  [ROB_DEPTH];
    logic [DATA_W-1:0]      data_q [ROB_DEPTH];
    logic [DATA_W-1:0]      data_d [ROB_DEPTH];

    logic [ID_W:0]          count;
    logic [ID_W:0]          n_alloc;
    logic [ID_W:0]          n_retire;
    logic [ID_W-1:0]        ret_idx [MACHINE_WIDTH];
    logic                   ret_chain;
    logic                   do_alloc;

    // Wrap bit in the pointers keeps full (count=ROB_DEPTH) distinct from empty.
    assign count       = tail_q - head_q;
    assign alloc_ready = (ROB_DEPTH - int'(count)) >= MACHINE_WIDTH;
    assign empty       = (count == '0);
    assign do_alloc    = alloc_ready && !flush;

    // Valid lanes get compact indices; idle lanes still see the next free slot.
    always_comb begin
        n_alloc = '0;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            rob_addr_new[i] = tail_q[ID_W-1:0] + n_alloc[ID_W-1:0];
            if (alloc_valid[i]) begin
                n_alloc = n_alloc + PTR_ONE;
            end
        end
    end

    always_comb begin
        n_retire  = '0;
        ret_chain = !flush;
        for (int i = 0; i < MACHINE_WIDTH; i++) begin
            ret_idx[i]      = head_q[ID_W-1:0] + ID_W'(i);
            ret_chain       = ret_chain && valid_q[ret_idx[i]] && done_q[ret_idx[i]];
            retire_valid[i] = ret_chain;
            retire_preg[i]  = ret_idx[i];
            retire_dst[i]   = dst_q[ret_idx[i]];
            retire_data[i]  = data_q[ret_idx[i]];
            if (ret_chain) begin
                n_retire = n_retire + PTR_ONE;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        dst_d   = dst_q;
        data_d  = data_q;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
        end else begin
            // Later lanes overwrite earlier ones when they target the same entry.
            for (int l = 0; l < MACHINE_WIDTH; l++) begin
                if (wb_valid[l] && valid_q[wb_id[l]]) begin
                    done_d[wb_id[l]] = 1'b1;
                    data_d[wb_id[l]] = wb_data[l];
                end
            end
            for (int i = 0; i < MACHINE_WIDTH; i++) begin
                if (retire_valid[i]) begin
                    valid_d[ret_idx[i]] = 1'b0;
                    done_d[ret_idx[i]]  = 1'b0;
                end
            end
            if (do_alloc) begin
                for (int l = 0; l < MACHINE_WIDTH; l++) begin
                    if (alloc_valid[l]) begin
                        valid_d[rob_addr_new[l]] = 1'b1;
                        done_d[rob_addr_new[l]]  = 1'b0;
                        dst_d[rob_addr_new[l]]   = alloc_dst[l];
                    end
                end
                tail_d = tail_q + n_alloc;
            end
            head_d = head_q + n_retire;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
        end
    end

    // Payload is qualified by valid/done, so it needs no reset.
    always_ff @(posedge clk) begin
        dst_q  <= dst_d;
        data_q <= data_d;
    end

endmodule

// File: tb/tb_rob.sv
// Directed bench for rob: a queue-based model of in-order commit checked every
// cycle, plus literal expectations for the key scenarios.
module tb_rob;

    localparam int MW    = 2;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              resetn;
    logic              flush;
    logic [MW-1:0]     alloc_valid;
    logic [MW-1:0][6:0]  alloc_dst;
    logic              alloc_ready;
    logic [MW-1:0][3:0]  rob_addr_new;
    logic [MW-1:0]     wb_valid;
    logic [MW-1:0][3:0]  wb_id;
    logic [MW-1:0][31:0] wb_data;
    logic [MW-1:0]     retire_valid;
    logic [MW-1:0][6:0]  retire_dst;
    logic [MW-1:0][3:0]  retire_preg;
    logic [MW-1:0][31:0] retire_data;
    logic              empty;

    rob #(.MACHINE_WIDTH(MW), .ROB_DEPTH(DEPTH)) dut (
        .clk(clk), .resetn(resetn), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_dst(alloc_dst), .alloc_ready(alloc_ready),
        .rob_addr_new(rob_addr_new), .wb_valid(wb_valid), .wb_id(wb_id), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_dst(retire_dst), .retire_preg(retire_preg),
        .retire_data(retire_data), .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [6:0]  dst;
        bit          done;
        logic [31:0] data;
    } ent_t;

    ent_t q[$];
    int   tail_m = 0;
    bit   init_m = 1'b0;
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Expected outputs follow from the in-order queue of outstanding instructions.
    task automatic model_check();
        int  below;
        bit  chain;
        if (!init_m) return;
        chk("alloc_ready", alloc_ready, (DEPTH - q.size()) >= MW);
        chk("empty", empty, q.size() == 0);
        below = 0;
        for (int l = 0; l < MW; l++) begin
            chk("rob_addr_new", rob_addr_new[l], (tail_m + below) % DEPTH);
            if (alloc_valid[l]) below++;
        end
        chain = !flush;
        for (int l = 0; l < MW; l++) begin
            chain = chain && (l < q.size()) && q[l].done;
            chk("retire_valid", retire_valid[l], chain);
            if (chain) begin
                chk("retire_preg", retire_preg[l], q[l].idx);
                chk("retire_dst", retire_dst[l], q[l].dst);
                chk("retire_data", retire_data[l], q[l].data);
            end
        end
    endtask

    task automatic model_update();
        int  r;
        int  n;
        bit  ready;
        ent_t e;
        if (!resetn) begin
            q.delete();
            tail_m = 0;
            init_m = 1'b1;
        end else if (!init_m) begin
            return;
        end else if (flush) begin
            q.delete();
            tail_m = 0;
        end else begin
            ready = (DEPTH - q.size()) >= MW;
            r = 0;
            while (r < MW && r < q.size() && q[r].done) r++;
            for (int l = 0; l < MW; l++) begin
                if (wb_valid[l]) begin
                    for (int k = 0; k < q.size(); k++) begin
                        if (q[k].idx == int'(wb_id[l])) begin
                            q[k].done = 1'b1;
                            q[k].data = wb_data[l];
                        end
                    end
                end
            end
            for (int k = 0; k < r; k++) void'(q.pop_front());
            if (ready) begin
                n = 0;
                for (int l = 0; l < MW; l++) begin
                    if (alloc_valid[l]) begin
                        e.idx  = (tail_m + n) % DEPTH;
                        e.dst  = alloc_dst[l];
                        e.done = 1'b0;
                        e.data = '0;
                        q.push_back(e);
                        n++;
                    end
                end
                tail_m = (tail_m + n) % DEPTH;
            end
        end
    endtask

    task automatic idle();
        resetn      = 1'b1;
        flush       = 1'b0;
        alloc_valid = '0;
        alloc_dst   = '0;
        wb_valid    = '0;
        wb_id       = '0;
        wb_data     = '0;
    endtask

    task automatic cyc();
        #1;
        model_check();
        @(posedge clk);
        model_update();
        @(negedge clk);
        idle();
    endtask

    task automatic alloc2(input logic [1:0] v, input logic [6:0] d0, input logic [6:0] d1);
        alloc_valid  = v;
        alloc_dst[0] = d0;
        alloc_dst[1] = d1;
    endtask

    task automatic wb(input int lane, input int id, input logic [31:0] d);
        wb_valid[lane] = 1'b1;
        wb_id[lane]    = id[3:0];
        wb_data[lane]  = d;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        cyc();
        resetn = 1'b0;
        cyc();

        // Reset state and first dual allocation
        alloc2(2'b11, 7'd5, 7'd7);
        #1;
        chk("lit_reset_ready", alloc_ready, 1);
        chk("lit_reset_empty", empty, 1);
        chk("lit_reset_rv", retire_valid, 0);
        chk("lit_addr0", rob_addr_new[0], 0);
        chk("lit_addr1", rob_addr_new[1], 1);
        cyc();
        #1;
        chk("lit_tail2", rob_addr_new[0], 2);
        chk("lit_not_empty", empty, 0);
        chk("lit_no_retire", retire_valid, 0);

        // Out-of-order writeback, no bypass to retire
        wb(0, 1, 32'hB1);
        cyc();
        #1;
        chk("lit_wait_idx0", retire_valid, 0);
        wb(0, 0, 32'hA0);
        cyc();
        #1;
        chk("lit_rv11", retire_valid, 2'b11);
        chk("lit_preg0", retire_preg[0], 0);
        chk("lit_preg1", retire_preg[1], 1);
        chk("lit_dst0", retire_dst[0], 5);
        chk("lit_dst1", retire_dst[1], 7);
        chk("lit_data1", retire_data[1], 32'hB1);
        cyc();
        #1;
        chk("lit_drained", empty, 1);

        // Non-contiguous lane pattern
        alloc2(2'b01, 7'd9, 7'd0);
        cyc();
        alloc2(2'b10, 7'd0, 7'd10);
        #1;
        chk("lit_compact_idx", rob_addr_new[1], 3);
        cyc();
        #1;
        chk("lit_tail4", rob_addr_new[0], 4);
        wb(0, 2, 32'h22);
        wb(1, 3, 32'h33);
        cyc();
        cyc();

        // Partial completion holds later entries; same-index wb, higher lane wins
        alloc2(2'b11, 7'd20, 7'd21);
        cyc();
        alloc2(2'b11, 7'd22, 7'd23);
        cyc();
        wb(0, 4, 32'h40);
        wb(1, 6, 32'h60);
        cyc();
        #1;
        chk("lit_rv01", retire_valid, 2'b01);
        chk("lit_preg4", retire_preg[0], 4);
        wb(0, 5, 32'h50);
        cyc();
        #1;
        chk("lit_rv_5_6", retire_valid, 2'b11);
        chk("lit_preg6", retire_preg[1], 6);
        wb(0, 7, 32'h111);
        wb(1, 7, 32'h222);
        cyc();
        #1;
        chk("lit_lane_wins", retire_data[0], 32'h222);
        cyc();

        // Reset overrides a simultaneous allocation
        alloc2(2'b11, 7'd1, 7'd2);
        resetn = 1'b0;
        cyc();
        #1;
        chk("lit_reset_mid", empty, 1);

        // Fill to 15, then 16 across the wrap
        for (int k = 0; k < 7; k++) begin
            alloc2(2'b11, 7'(k), 7'(k + 1));
            cyc();
        end
        alloc2(2'b01, 7'd30, 7'd0);
        cyc();
        #1;
        chk("lit_ready_15", alloc_ready, 0);
        alloc2(2'b11, 7'd40, 7'd41);
        cyc();
        #1;
        chk("lit_ignored", rob_addr_new[0], 15);
        wb(0, 0, 32'h1000);
        cyc();
        alloc2(2'b11, 7'd42, 7'd43);
        #1;
        chk("lit_no_credit", alloc_ready, 0);
        chk("lit_rv_one", retire_valid, 2'b01);
        cyc();
        alloc2(2'b11, 7'd44, 7'd45);
        #1;
        chk("lit_ready_14", alloc_ready, 1);
        chk("lit_wrap0", rob_addr_new[0], 15);
        chk("lit_wrap1", rob_addr_new[1], 0);
        cyc();
        #1;
        chk("lit_full_ready", alloc_ready, 0);
        chk("lit_full_empty", empty, 0);
        wb(0, 1, 32'h11);
        wb(1, 2, 32'h12);
        cyc();
        cyc();
        #1;
        chk("lit_ready_again", alloc_ready, 1);

        // Flush with completed entries at head; HI/LO destination
        flush = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            alloc2(2'b11, 7'(50 + k), 7'(60 + k));
            cyc();
        end
        wb(0, 0, 32'h70);
        wb(1, 1, 32'h71);
        cyc();
        flush = 1'b1;
        alloc2(2'b11, 7'd3, 7'd4);
        wb(0, 2, 32'h72);
        #1;
        chk("lit_flush_rv", retire_valid, 0);
        cyc();
        alloc2(2'b11, 7'h43, 7'd8);
        #1;
        chk("lit_flush_empty", empty, 1);
        chk("lit_flush_addr0", rob_addr_new[0], 0);
        chk("lit_flush_addr1", rob_addr_new[1], 1);
        cyc();
        wb(0, 0, 32'hDEAD);
        cyc();
        #1;
        chk("lit_hilo_rv", retire_valid, 2'b01);
        chk("lit_hilo_dst", retire_dst[0], 7'h43);
        cyc();
        wb(1, 1, 32'hBEEF);
        cyc();
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rob.md
ROB -- requirements
Module: rob

Interface
REQ-001 Parameter MACHINE_WIDTH, default 2: allocate/writeback/retire lanes per cycle.
REQ-002 Parameter ROB_DEPTH, default 16 (power of 2): entry count; ID_W = log2(ROB_DEPTH) = 4.
REQ-003 Reset is resetn, synchronous, active-low; clock is clk.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 resetn  in  1  synchronous active-low reset.
REQ-006 flush  in  1  synchronous squash of all entries.
REQ-007 alloc_valid  in  MACHINE_WIDTH  per-lane allocation request.
REQ-008 alloc_dst  in  MACHINE_WIDTH x 7  architectural destination (7'b1000011 = HI/LO pair).
REQ-009 alloc_ready  out  1  at least MACHINE_WIDTH entries free.
REQ-010 rob_addr_new  out  MACHINE_WIDTH x ID_W  ROB index assigned per lane, combinational.
REQ-011 wb_valid  in  MACHINE_WIDTH  completion strobe per lane.
REQ-012 wb_id  in  MACHINE_WIDTH x ID_W  completing ROB index.
REQ-013 wb_data  in  MACHINE_WIDTH x 32  result.
REQ-014 retire_valid  out  MACHINE_WIDTH  in-order commit this cycle.
REQ-015 retire_dst  out  MACHINE_WIDTH x 7  committed architectural destination.
REQ-016 retire_preg  out  MACHINE_WIDTH x ID_W  committed ROB index (matched by RAT to clear mapping).
REQ-017 retire_data  out  MACHINE_WIDTH x 32  committed result.
REQ-018 empty  out  1  no valid entries.

Function
REQ-019 Circular buffer; head/tail pointers ID_W+1 bits (wrap bit); count = tail - head, range 0..ROB_DEPTH.
REQ-020 alloc_ready = (ROB_DEPTH - count) >= MACHINE_WIDTH, from registered state only; no same-cycle credit from retires.
REQ-021 Lane i index = tail + (number of valid lanes below i), mod ROB_DEPTH; non-contiguous patterns (e.g. 2'b10) get compact indices.
REQ-022 Allocation takes effect at clock edge when alloc_ready=1: entry valid=1, done=0, dst stored; tail += popcount(alloc_valid).
REQ-023 alloc_valid while alloc_ready=0: ignored, no state change; rob_addr_new still driven.
REQ-024 Writeback sets done=1, stores data at edge; wb to an invalid entry is ignored; same-cycle wb to same index, higher lane wins.
REQ-025 Writeback is not bypassed to retire: entry written in cycle N retires no earlier than N+1.
REQ-026 retire_valid[0] = head entry valid & done; retire_valid[i] = retire_valid[i-1] & entry head+i valid & done (strictly in order).
REQ-027 Retired entries cleared (valid=0, done=0) and head += popcount(retire_valid) at edge.
REQ-028 Allocation and retirement in same cycle both apply; count updates by net difference.
REQ-029 Full (count=ROB_DEPTH) and wrap-around of index ROB_DEPTH-1 -> 0 handled by wrap bit; full and empty distinguished.
REQ-030 flush: retire_valid forced 0 that cycle; all entries invalid, head=tail=0 at edge; alloc and wb ignored that cycle.
REQ-031 empty = (count = 0); retire_dst/preg/data don't-care when corresponding retire_valid=0.

Reset
REQ-032 resetn=0 at edge: head=tail=0, all valid/done=0; outputs after: alloc_ready=1, empty=1, retire_valid=0, rob_addr_new = {0,1}.
REQ-033 Reset mid-operation discards all entries; reset overrides flush and alloc.

Verification
REQ-034 Reset, alloc_valid=2'b11 dst {5,7} -> rob_addr_new {0,1}; next cycle tail=2, empty=0, retire_valid=0.
REQ-035 wb idx1 then idx0 in consecutive cycles -> no retire after first wb; cycle after second wb retire_valid=2'b11, preg {0,1}, dst {5,7}.
REQ-036 Fill 16 entries -> alloc_ready=0 at count 15 and 16; further alloc ignored; retire 2 -> alloc_ready=1, next indices wrap to 0,1.
REQ-037 alloc_valid=2'b10 at tail=3 -> rob_addr_new[1]=3; tail becomes 4.
REQ-038 Entries 0..3 pending, done on 0,2 only -> retire_valid=2'b01 (idx 0), entry 2 held until 1 done.
REQ-039 Flush with 6 entries, 2 done at head -> retire_valid=0 that cycle; next cycle empty=1, rob_addr_new={0,1}; HI/LO dst 7'b1000011 retires with same dst.
